mul_div_unit: RTL and testbench

//  Iterative multiply/divide unit sitting beside the single-cycle ALU in the EX stage.

---
 rtl/mul_div_unit_if.sv | 24 ++
 rtl/mul_div_unit.sv | 132 +++++++++++++
 tb/tb_mul_div_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Operand/control and HI/LO result bundle shared between the EX-stage issue logic
// and the iterative multiply/divide unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, ctrl_i, src1_i, src2_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider producing the HI/LO pair.
// Signed ops run on magnitudes; signs are applied in a single fix-up cycle.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO handled here in one edge
// S_CALC | WIDTH iterations, counter counts WIDTH-1 down to 0
// S_FIX  | apply result signs and write HI/LO
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic           clk_i,
  input logic           rst_i,
  mul_div_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH:0]       rem;
  logic [WIDTH-1:0]     opb;
  logic                 is_div, neg_q, neg_r, div0;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic                 is_calc, is_mt, signed_op;
  logic                 src1_neg, src2_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift, div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign is_calc   = (bus.ctrl_i[3:2] == 2'b10);
  assign is_mt     = (bus.ctrl_i[3:1] == 3'b110);
  assign signed_op = ~bus.ctrl_i[0];
  assign src1_neg  = signed_op & bus.src1_i[WIDTH-1];
  assign src2_neg  = signed_op & bus.src2_i[WIDTH-1];
  assign a_mag     = src1_neg ? (~bus.src1_i + WIDTH'(1)) : bus.src1_i;
  assign b_mag     = src2_neg ? (~bus.src2_i + WIDTH'(1)) : bus.src2_i;

  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? opb : '0)};
  // borrow out of the (WIDTH+1)-bit subtract means the trial subtraction failed
  assign div_shift = {rem[WIDTH-1:0], prod[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};

  assign prod_fix  = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
  assign quo_fix   = div0 ? '1 : (neg_q ? (~prod[WIDTH-1:0] + WIDTH'(1)) : prod[WIDTH-1:0]);
  assign rem_fix   = neg_r ? (~rem[WIDTH-1:0] + WIDTH'(1)) : rem[WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start_i && is_calc) state_nxt = S_CALC;
      S_CALC:  if (cnt == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      prod   <= '0;
      rem    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i && is_calc) begin
            cnt    <= CNT_W'(WIDTH - 1);
            prod   <= {{WIDTH{1'b0}}, a_mag};
            rem    <= '0;
            opb    <= b_mag;
            is_div <= bus.ctrl_i[1];
            neg_q  <= src1_neg ^ src2_neg;
            neg_r  <= src1_neg;
            div0   <= (bus.src2_i == '0);
          end else if (bus.start_i && is_mt) begin
            if (bus.ctrl_i[0]) lo_q <= bus.src1_i;
            else               hi_q <= bus.src1_i;
            done_q <= 1'b1;
          end
        end
        S_CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (!is_div) begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
          end else if (!div_diff[WIDTH]) begin
            rem              <= div_diff;
            prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], 1'b1};
          end else begin
            rem              <= div_shift;
            prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], 1'b0};
          end
        end
        S_FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o = (state != S_IDLE);
  assign bus.done_o = done_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes hand-computed HI/LO and busy
// lengths; a monitor pops and compares on every done pulse.
module tb_mul_div_unit;

  localparam logic [3:0] C_MULT  = 4'b1000;
  localparam logic [3:0] C_MULTU = 4'b1001;
  localparam logic [3:0] C_DIV   = 4'b1010;
  localparam logic [3:0] C_DIVU  = 4'b1011;
  localparam logic [3:0] C_MTHI  = 4'b1100;
  localparam logic [3:0] C_MTLO  = 4'b1101;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] busy_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   busy_cnt = 0;
  exp_t sb_q[$];

  mul_div_unit_if #(.WIDTH(32)) bus();

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // monitor: samples 1 time unit after each rising edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) begin
        if (sb_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: got done_o=1, expected no pending result");
        end else begin
          e = sb_q.pop_front();
          check("hi", bus.hi_o, e.hi);
          check("lo", bus.lo_o, e.lo);
          check("busy_cycles", 32'(busy_cnt), e.busy_n);
          check("busy_in_done", {31'd0, bus.busy_o}, 32'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy_o) begin
      total++;
      $display("FAIL idle_timeout: got busy_o=1 after %0d cycles, expected 0", n);
    end
  endtask

  // called at a falling edge; returns at the falling edge after the start edge
  task automatic issue(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int ebusy,
                       input bit push);
    wait_idle();
    if (push) sb_q.push_back({ehi, elo, 32'(ebusy)});
    bus.start_i = 1'b1;
    bus.ctrl_i  = ctrl;
    bus.src1_i  = a;
    bus.src2_i  = b;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.ctrl_i  = C_MULTU;
    bus.src1_i  = ~a;
    bus.src2_i  = ~b;
  endtask

  initial begin
    int n;
    bus.start_i = 1'b0;
    bus.ctrl_i  = 4'd0;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_done", {31'd0, bus.done_o}, 32'd0);
    check("rst_hi", bus.hi_o, 32'd0);
    check("rst_lo", bus.lo_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(C_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1);
    issue(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1);
    issue(C_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, 1);
    issue(C_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 33, 1);
    issue(C_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1);
    issue(C_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 33, 1);
    issue(C_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1);
    issue(C_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 33, 1);
    issue(C_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1);
    issue(C_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 33, 1);

    // start pulse while busy must be ignored
    issue(C_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 33, 1);
    repeat (4) @(negedge clk);
    bus.start_i = 1'b1;
    bus.ctrl_i  = C_MTHI;
    bus.src1_i  = 32'hDEADBEEF;
    @(negedge clk);
    bus.start_i = 1'b0;

    // abort a multiply with reset mid-operation
    issue(C_MULT, 32'd3, 32'd5, 32'd0, 32'd0, 0, 0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy_o}, 32'd0);
    check("abort_done", {31'd0, bus.done_o}, 32'd0);
    check("abort_hi", bus.hi_o, 32'd0);
    check("abort_lo", bus.lo_o, 32'd0);
    repeat (40) @(negedge clk);

    issue(C_MTHI,  32'h12345678, 32'd0, 32'h12345678, 32'h00000000, 0, 1);
    check("mthi_edge_hi", bus.hi_o, 32'h12345678);
    issue(C_MTLO,  32'h9ABCDEF0, 32'd0, 32'h12345678, 32'h9ABCDEF0, 0, 1);
    check("mtlo_edge_lo", bus.lo_o, 32'h9ABCDEF0);
    issue(C_MULTU, 32'd2, 32'd3, 32'h00000000, 32'h00000006, 33, 1);

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending results, expected 0", sb_q.size());
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
